equal_iter: RTL and testbench
=============================

# equal_iter

Parametrised, sequential successor to the combinational 64-bit equality block. Compares two WIDTH-bit operands one CHUNK-bit slice per cycle, most-significant slice first, and terminates early on the first differing slice. Supports equality, inequality, unsigned less-than and signed less-than. Sits between operand producers and consumers in the datapath behind a valid/ready handshake on both sides, so it trades latency for a narrow per-cycle comparator on wide operands.

## Interface
- WIDTH, 64: operand width in bits.
- CHUNK, 16: slice width compared per cycle.
  - WIDTH % CHUNK must equal 0; elaboration fails otherwise.
  - NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block can accept. Equals 1 only in IDLE.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- op  in  2  compare mode:
  - 00 EQ: A==B.
  - 01 NE: A!=B.
  - 10 LTU: A<B unsigned.
  - 11 LTS: A<B two's-complement.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- Z  out  WIDTH  result, zero-extended: Z[0] is the compare outcome; Z[WIDTH-1:1] is always 0.
- n_cycles  out  clog2(NCHUNK)+1  number of slices examined for the current result.

## Operation
- State machine with states IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch A, B and op into internal registers. For LTS, invert bit WIDTH-1 of both latched copies so that an unsigned compare gives the signed result.
  - Set the slice index to NCHUNK-1 and go to BUSY.
- BUSY: each cycle compare slice idx of the latched operands.
  - Slices differ: record eq=0 and lt=(slice A < slice B), then go to DONE.
  - Slices equal and idx==0: record eq=1, lt=0, then go to DONE.
  - Slices equal and idx>0: decrement idx and stay in BUSY.
  - n_cycles counts the slices examined.
- DONE:
  - out_valid=1.
  - Z[0] = eq for EQ, !eq for NE, lt for LTU/LTS.
  - Z, n_cycles and out_valid hold stable until out_ready=1.
  - On out_valid & out_ready, go to IDLE.
- Inputs A, B and op are ignored outside the IDLE accept cycle. Changing them during BUSY or DONE has no effect on the result.
- Reset (rst_n=0, any state, including mid-BUSY):
  - State goes to IDLE immediately and the pending compare is discarded.
  - Output values: in_ready=1, out_valid=0, Z=0, n_cycles=0.
  - Internal operand registers clear to 0.

## Timing
- Accept occurs on the edge where in_valid & in_ready.
- out_valid rises k edges after acceptance, where k = NCHUNK - i and i is the index of the highest differing slice.
  - k = NCHUNK when operands are equal.
  - Minimum latency 1, maximum NCHUNK.
- The result is consumed on the edge with out_valid & out_ready. in_ready is 1 in the following cycle.
- No back-to-back issue: a new accept happens no earlier than 1 cycle after consume.
- Throughput: at most one compare per k+2 cycles.
- out_ready held high has no effect outside DONE.
- in_valid held high while the block is busy has no effect; the operands are taken at the next IDLE cycle.

## Test plan
All scenarios use WIDTH=64, CHUNK=16 (NCHUNK=4).
- Reset: hold rst_n=0, then release. Outputs read in_ready=1, out_valid=0, Z=0. Assert rst_n=0 mid-BUSY and check the same values immediately and that no stray result appears afterward.
- A=5, B=1, op=EQ, out_ready=1: Z=0, n_cycles=4, out_valid 4 edges after accept. Then A=10, B=10, EQ: Z=1, n_cycles=4.
- A=-5, B=10:
  - op=LTS: Z=1, n_cycles=1.
  - op=LTU: Z=0, n_cycles=1.
  - op=NE: Z=1, n_cycles=1.
- A={64{1'b1}}, B=10, op=NE: Z=1, latency 1. Same operands with op=EQ: Z=0.
- Backpressure: A=1, B=2, op=LTU, out_ready=0 for 5 cycles. out_valid stays 1 and Z=1, n_cycles=4 stay stable; in_ready stays 0. Change A/B during the stall: no effect. Raise out_ready: consume, then in_ready=1 the next cycle.
- Randomised sweep with a scoreboard against a reference model: 1000 operand pairs with biased equal upper slices, all four ops, random out_ready. Check Z, n_cycles and that every latency is in 1..4.

Source files
------------

// File: rtl/equal_iter.sv
// Iterative WIDTH-bit comparator: scans CHUNK-bit slices from the MSB down,
// stopping on the first differing slice. Supports EQ/NE/LTU/LTS behind valid/ready.
module equal_iter #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  A,
   input  logic [WIDTH-1:0]                  B,
   input  logic [1:0]                        op,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WIDTH-1:0]                  Z,
   output logic [$clog2(WIDTH/CHUNK):0]      n_cycles
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int NW     = $clog2(NCHUNK) + 1;

   localparam logic [1:0] OP_EQ  = 2'b00;
   localparam logic [1:0] OP_NE  = 2'b01;
   localparam logic [1:0] OP_LTS = 2'b11;

   generate
      if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
         $error("equal_iter: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [1:0]        op_q, op_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              z_q, z_d;
   logic [NW-1:0]     ncyc_q, ncyc_d;

   logic [CHUNK-1:0]  a_slice [NCHUNK];
   logic [CHUNK-1:0]  b_slice [NCHUNK];
   logic [CHUNK-1:0]  cur_a;
   logic [CHUNK-1:0]  cur_b;
   logic              slice_eq;
   logic              slice_lt;
   logic              scan_end;
   logic              result_bit;

   // Slice views of the latched operands; only the indexed one reaches the comparator.
   generate
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
         assign a_slice[gi] = a_q[gi*CHUNK +: CHUNK];
         assign b_slice[gi] = b_q[gi*CHUNK +: CHUNK];
      end
   endgenerate

   assign cur_a    = a_slice[idx_q];
   assign cur_b    = b_slice[idx_q];
   assign slice_eq = (cur_a == cur_b);
   assign slice_lt = (cur_a < cur_b);
   assign scan_end = !slice_eq || (idx_q == '0);

   // Equal-at-slice-0 yields eq=1, lt=0, which slice_eq/slice_lt already give.
   always_comb begin
      result_bit = slice_lt;
      case (op_q)
         OP_EQ:   result_bit = slice_eq;
         OP_NE:   result_bit = !slice_eq;
         default: result_bit = slice_lt;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      idx_d       = idx_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      z_d         = z_q;
      ncyc_d      = ncyc_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d  = A;
               b_d  = B;
               op_d = op;
               // Flipping both sign bits turns the unsigned scan into a signed compare.
               if (op == OP_LTS) begin
                  a_d[WIDTH-1] = ~A[WIDTH-1];
                  b_d[WIDTH-1] = ~B[WIDTH-1];
               end
               idx_d      = IW'(NCHUNK - 1);
               z_d        = 1'b0;
               ncyc_d     = '0;
               in_ready_d = 1'b0;
               state_d    = S_BUSY;
            end
         end
         S_BUSY: begin
            if (scan_end) begin
               z_d         = result_bit;
               ncyc_d      = NW'(NCHUNK) - NW'(idx_q);
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         idx_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         z_q         <= 1'b0;
         ncyc_q      <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         z_q         <= z_d;
         ncyc_q      <= ncyc_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Z         = {{(WIDTH-1){1'b0}}, z_q};
   assign n_cycles  = ncyc_q;

endmodule

// File: tb/tb_equal_iter.sv
// Scoreboard bench for equal_iter (WIDTH=64, CHUNK=16): directed cases,
// backpressure, mid-scan reset and a randomised sweep against a reference model.
module tb_equal_iter;

   localparam int W  = 64;
   localparam int C  = 16;
   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [1:0]    op = 2'b00;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  Z;
   logic [2:0]    n_cycles;

   always #5 clk = ~clk;

   equal_iter #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Z         (Z),
      .n_cycles  (n_cycles)
   );

   typedef struct {
      logic z;
      int   n;
      int   acc;
   } exp_t;

   exp_t  sb [$];
   exp_t  mon_e;
   int    n_assert = 0;
   int    n_fail = 0;
   int    cyc = 0;
   int    n_txn = 0;
   bit    lat_done = 0;
   logic  last_z = 1'b0;
   int    last_n = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
      exp_t e;
      int   hi;
      hi = -1;
      for (int s = 0; s < NC; s++)
         if (a[s*C +: C] != b[s*C +: C]) hi = s;
      e.n = (hi < 0) ? NC : NC - hi;
      case (o)
         2'b00:   e.z = (a == b);
         2'b01:   e.z = (a != b);
         2'b10:   e.z = (a < b);
         default: e.z = ($signed(a) < $signed(b));
      endcase
      e.acc = 0;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Push on the accept handshake, compare latency and result when the DUT answers.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            mon_e     = model(A, B, op);
            mon_e.acc = cyc + 1;
            sb.push_back(mon_e);
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               check_val("stray_result", 64'(out_valid), 64'd0);
            end else begin
               if (!lat_done) begin
                  check_val("latency", 64'(cyc - sb[0].acc), 64'(sb[0].n));
                  lat_done = 1;
               end
               if (out_ready) begin
                  mon_e = sb.pop_front();
                  check_val("z", Z, 64'(mon_e.z));
                  check_val("n_cycles", 64'(n_cycles), 64'(mon_e.n));
                  last_z   = Z[0];
                  last_n   = int'(n_cycles);
                  lat_done = 0;
                  n_txn++;
                  $display("txn %0d: z=%0b n_cycles=%0d (model z=%0b n=%0d)",
                           n_txn, Z[0], n_cycles, mon_e.z, mon_e.n);
               end
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
      int t;
      bit acc;
      @(posedge clk); #1;
      A = a;
      B = b;
      op = o;
      in_valid = 1'b1;
      t = 0;
      acc = 0;
      while (!acc && t < 20) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         t++;
      end
      in_valid = 1'b0;
      if (!acc) check_val("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain(input bit rnd);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 60) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         t++;
      end
      if (sb.size() != 0) begin
         check_val("result_timeout", 64'd0, 64'd1);
         sb.delete();
      end
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o, input bit rnd);
      send(a, b, o);
      drain(rnd);
   endtask

   initial begin
      int t;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int k;

      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_in_ready", 64'(in_ready), 64'd1);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_z", Z, 64'd0);
      check_val("rst_n_cycles", 64'(n_cycles), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
      check_val("post_rst_out_valid", 64'(out_valid), 64'd0);

      out_ready = 1'b1;
      issue(64'd5, 64'd1, 2'b00, 0);
      check_val("eq_5_1_z", 64'(last_z), 64'd0);
      check_val("eq_5_1_n", 64'(last_n), 64'd4);
      issue(64'd10, 64'd10, 2'b00, 0);
      check_val("eq_10_10_z", 64'(last_z), 64'd1);
      check_val("eq_10_10_n", 64'(last_n), 64'd4);

      issue(-64'sd5, 64'd10, 2'b11, 0);
      check_val("lts_m5_10_z", 64'(last_z), 64'd1);
      check_val("lts_m5_10_n", 64'(last_n), 64'd1);
      issue(-64'sd5, 64'd10, 2'b10, 0);
      check_val("ltu_m5_10_z", 64'(last_z), 64'd0);
      check_val("ltu_m5_10_n", 64'(last_n), 64'd1);
      issue(-64'sd5, 64'd10, 2'b01, 0);
      check_val("ne_m5_10_z", 64'(last_z), 64'd1);
      check_val("ne_m5_10_n", 64'(last_n), 64'd1);

      issue({64{1'b1}}, 64'd10, 2'b01, 0);
      check_val("ne_ones_z", 64'(last_z), 64'd1);
      check_val("ne_ones_n", 64'(last_n), 64'd1);
      issue({64{1'b1}}, 64'd10, 2'b00, 0);
      check_val("eq_ones_z", 64'(last_z), 64'd0);

      // Backpressure: result must hold while out_ready is low and inputs wiggle.
      out_ready = 1'b0;
      send(64'd1, 64'd2, 2'b10);
      t = 0;
      while (!out_valid && t < 10) begin
         @(posedge clk); #1;
         t++;
      end
      check_val("bp_out_valid_rise", 64'(out_valid), 64'd1);
      repeat (5) begin
         @(negedge clk);
         check_val("bp_out_valid", 64'(out_valid), 64'd1);
         check_val("bp_z", Z, 64'd1);
         check_val("bp_n_cycles", 64'(n_cycles), 64'd4);
         check_val("bp_in_ready", 64'(in_ready), 64'd0);
         A  = {$urandom, $urandom};
         B  = {$urandom, $urandom};
         op = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain(0);
      check_val("bp_consume_z", 64'(last_z), 64'd1);
      check_val("bp_in_ready_after", 64'(in_ready), 64'd1);

      // Reset in the middle of a four-slice scan.
      send(64'd5, 64'd1, 2'b00);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      sb.delete();
      lat_done = 0;
      check_val("midrst_in_ready", 64'(in_ready), 64'd1);
      check_val("midrst_out_valid", 64'(out_valid), 64'd0);
      check_val("midrst_z", Z, 64'd0);
      check_val("midrst_n_cycles", 64'(n_cycles), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_val("midrst_no_stray", 64'(out_valid), 64'd0);

      // Randomised sweep with biased equal upper slices.
      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom, $urandom};
         rb = ra;
         k  = $urandom_range(0, 4);
         if (k < NC) begin
            for (int s = 0; s <= k; s++) rb[s*C +: C] = 16'($urandom);
         end
         issue(ra, rb, 2'($urandom_range(0, 3)), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
